product_accumulator_16: RTL and testbench

//  Downstream consumer of the 8x8 array multiplier's 16-bit unsigned product.

---
 rtl/product_accumulator_16.sv | 130 +++++++++++++
 tb/tb_product_accumulator_16.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator_16.sv
// product_accumulator_16: multiply-accumulate stage behind the 8x8 array
// multiplier. It sums N_TERMS unsigned products into a saturating ACC_W-bit
// result and presents that result under a valid/ready handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// ACC   | collecting products; in_ready high unless clear is asserted
// HOLD  | completed result on acc_out/overflow, waiting for out_ready
module product_accumulator_16 #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,
    parameter int N_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sticky_q, sticky_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               last_beat;
    logic [SUM_W-1:0]   sum;
    logic               sat_hit;
    logic [ACC_W-1:0]   sat_val;

    // Handshake and saturating adder. One extra bit on the sum is enough to
    // detect overflow because a single product never exceeds the ACC_W range.
    always_comb begin
        in_ready  = (state_q == S_ACC) && !clear;
        accept    = in_valid && in_ready;
        last_beat = (count_q == CNT_W'(N_TERMS - 1));
        sum       = SUM_W'(acc_q) + SUM_W'(product);
        sat_hit   = sum[ACC_W];
        sat_val   = sat_hit ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    // Next-state and datapath update; clear overrides every state action.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sticky_d    = sticky_q;
        acc_out_d   = acc_out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            state_d     = S_ACC;
            acc_d       = '0;
            count_d     = '0;
            sticky_d    = 1'b0;
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (accept) begin
                        if (last_beat) begin
                            acc_out_d   = sat_val;
                            ovf_d       = sticky_q | sat_hit;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            count_d     = '0;
                            sticky_d    = 1'b0;
                            state_d     = S_HOLD;
                        end else begin
                            acc_d    = sat_val;
                            count_d  = count_q + 1'b1;
                            sticky_d = sticky_q | sat_hit;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_ACC;
                    end
                end
                default: state_d = S_ACC;
            endcase
        end
    end

    // State and datapath registers; reset discards any partial sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            count_q     <= '0;
            sticky_q    <= 1'b0;
            acc_out_q   <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sticky_q    <= sticky_d;
            acc_out_q   <= acc_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator_16.sv
// Directed bench for product_accumulator_16: a 24-bit and a 17-bit instance
// share all stimulus; the 17-bit one exposes saturation.
module tb_product_accumulator_16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] product;
    logic        clear;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, overflow_a;
    logic [23:0] acc_out_a;
    logic        in_ready_b, out_valid_b, overflow_b;
    logic [16:0] acc_out_b;

    int total = 0;
    int bad   = 0;

    product_accumulator_16 #(.PROD_W(16), .ACC_W(24), .N_TERMS(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .product(product), .clear(clear), .out_valid(out_valid_a),
        .out_ready(out_ready), .acc_out(acc_out_a), .overflow(overflow_a)
    );

    product_accumulator_16 #(.PROD_W(16), .ACC_W(17), .N_TERMS(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .product(product), .clear(clear), .out_valid(out_valid_b),
        .out_ready(out_ready), .acc_out(acc_out_b), .overflow(overflow_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            product  = p;
            tick();
        end
        in_valid = 1'b0;
        product  = 'x;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int pulses;
    int first_pos;
    int second_pos;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        product   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("rst_out_valid", 32'(out_valid_a), 0);
        chk("rst_acc_out", 32'(acc_out_a), 0);
        chk("rst_overflow", 32'(overflow_a), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready_a), 1);

        // Test 1: four beats summing to 98335
        beats(16'd0, 1);
        beats(16'd30, 1);
        beats(16'd33280, 1);
        chk("t1_not_yet_valid", 32'(out_valid_a), 0);
        beats(16'd65025, 1);
        chk("t1_out_valid", 32'(out_valid_a), 1);
        chk("t1_acc_out", 32'(acc_out_a), 98335);
        chk("t1_overflow", 32'(overflow_a), 0);
        chk("t1_b_acc_out", 32'(acc_out_b), 98335);

        // Test 2: hold with in_valid asserted, nothing consumed
        in_valid = 1'b1;
        product  = 16'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_acc", 32'(acc_out_a), 98335);
            chk("t2_hold_ready", 32'(in_ready_a), 0);
            chk("t2_hold_valid", 32'(out_valid_a), 1);
        end
        out_ready = 1'b1;
        tick();
        chk("t2_taken_valid", 32'(out_valid_a), 0);
        chk("t2_taken_ready", 32'(in_ready_a), 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Test 3: partial sum flushed by clear; beat offered during clear is ignored
        beats(16'd100, 1);
        beats(16'd200, 1);
        clear    = 1'b1;
        in_valid = 1'b1;
        product  = 16'd999;
        #1;
        chk("t3_clear_ready", 32'(in_ready_a), 0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        beats(16'd1, 4);
        chk("t3_out_valid", 32'(out_valid_a), 1);
        chk("t3_acc_out", 32'(acc_out_a), 4);
        drain();

        // Test 4: 17-bit instance saturates, sticky flag cleared for next result
        beats(16'd65025, 4);
        chk("t4_b_acc_sat", 32'(acc_out_b), 131071);
        chk("t4_b_ovf", 32'(overflow_b), 1);
        chk("t4_a_acc", 32'(acc_out_a), 260100);
        chk("t4_a_ovf", 32'(overflow_a), 0);
        drain();
        beats(16'd1, 4);
        chk("t4_b_acc_next", 32'(acc_out_b), 4);
        chk("t4_b_ovf_next", 32'(overflow_b), 0);
        drain();

        // Test 5: async reset mid-accumulation discards partial sum
        beats(16'd5, 1);
        tick();
        tick();
        beats(16'd7, 1);
        tick();
        chk("t5_pre_rst_acc", 32'(acc_out_a), 4);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(out_valid_a), 0);
        chk("t5_rst_acc", 32'(acc_out_a), 0);
        chk("t5_rst_ovf", 32'(overflow_b), 0);
        tick();
        rst = 1'b0;
        beats(16'd2, 4);
        chk("t5_out_valid", 32'(out_valid_a), 1);
        chk("t5_acc_out", 32'(acc_out_a), 8);
        drain();

        // Test 6: back-to-back with both handshakes held high
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        product    = 16'd10;
        pulses     = 0;
        first_pos  = -1;
        second_pos = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (out_valid_a) begin
                pulses++;
                chk("t6_acc_out", 32'(acc_out_a), 40);
                if (first_pos < 0) first_pos = i;
                else if (second_pos < 0) second_pos = i;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t6_pulses", 32'(pulses), 2);
        chk("t6_first_pos", 32'(first_pos), 4);
        chk("t6_period", 32'(second_pos - first_pos), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
